ysyx_24100029_clint: RTL
========================

// Module: ysyx_24100029_clint
// PURPOSE
// - AXI4 slave (responder) for the core-local timer, base 0x0200_0000; sits on the CLNT_* side of the
//   core's address crossbar, answering the AR/R and AW/W/B traffic it forwards.
// - Holds a free-running 64-bit mtime, readable (and writable) as two 32-bit words.
// - Read and write channels are independent FSMs; INCR bursts supported, IDs echoed.
// PARAMETERS
// - TICK_DIV   default 1    clock cycles per mtime increment (>=1)
// - ADDR_MASK  default 16'hFFFF   address bits decoded inside the CLINT window
// PORTS
// - clock    in   1   system clock; all state updates on rising edge
// - reset    in   1   asynchronous, active-high reset
// - awvalid/awready in/out 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2
// - wvalid/wready in/out 1; wdata in 32; wstrb in 4; wlast in 1
// - bvalid/bready out/in 1; bresp out 2; bid out 4
// - arvalid/arready in/out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2
// - rvalid/rready out/in 1; rdata out 32; rresp out 2; rlast out 1; rid out 4
// BEHAVIOUR
// - Reset values: mtime=0, prescaler=0, arready=1, awready=1, wready=0, rvalid=0, rlast=0,
//   bvalid=0, rdata=0, rresp=0, rid=0, bresp=0, bid=0. Reset mid-burst aborts it; no response issued.
// - Map (offset = addr & ADDR_MASK, word-aligned): 0x0 -> mtime[31:0], 0x4 -> mtime[63:32];
//   any other offset: read data 0 + rresp SLVERR(2'b10), write dropped + bresp SLVERR.
// - Timer: prescaler counts 0..TICK_DIV-1; mtime += 1 on wrap. 64-bit wrap to 0 is silent.
// - Read FSM R_IDLE -> R_DATA:
//   R_IDLE: arready=1; on arvalid&arready latch addr, arid, arlen, and snapshot full 64-bit mtime.
//   R_DATA: arready=0, rvalid=1 one cycle after AR accept; rdata from the snapshot, so a 2-beat
//   burst at 0x0 returns a coherent 64-bit value. Beat advances on rvalid&rready: addr+=4 unless
//   arburst==FIXED (WRAP treated as INCR); rlast=1 on beat arlen. rlast&rready -> R_IDLE, arready
//   reasserts next cycle. rresp evaluated per beat. rid = latched arid for all beats.
// - Write FSM W_IDLE -> W_DATA -> W_RESP:
//   W_IDLE: awready=1; on AW handshake latch addr, awid; wready=1 from next cycle.
//   W_DATA: each wvalid&wready beat updates the addressed mtime word byte-wise per wstrb; addr
//   steps as for reads. Any unmapped beat sets sticky SLVERR for the burst. wlast beat -> W_RESP
//   (wready=0). Beat count vs awlen is not checked; wlast alone terminates.
//   W_RESP: bvalid=1, bid=latched awid, bresp=OKAY or sticky SLVERR; bvalid&bready -> W_IDLE.
// - Simultaneous write beat and timer tick on same word: written value wins, tick is lost for
//   that cycle; tick on the other word's carry still applies to the untouched word only if no
//   write hits it. Written value becomes visible to a read snapshot taken the following cycle.
// - Concurrent AR and AW accepted in the same cycle; a read snapshot taken in the cycle of a write
//   beat returns the pre-write value.
// - arsize/awsize < 2 use full-word data; master selects lanes. No exclusive access; no ECC.
// STRUCTURE
// - Shared package: CLINT_BASE 32'h0200_0000, offsets MTIME_LO=0x0 / MTIME_HI=0x4, AXI resp codes
//   OKAY=2'b00 / SLVERR=2'b10, burst codes FIXED=2'b00 / INCR=2'b01, FSM state encodings.
// - One sub-module: ysyx_24100029_clint_timer (prescaler + 64-bit mtime, byte-write port, tick out).
// - Top holds the two channel FSMs, address steppers, snapshot register.
// TESTING
// - Reset, TICK_DIV=1, hold 10 cycles, single read 0x0200_0000 -> rdata ~= cycle count, rresp=0,
//   rlast=1, rid=arid.
// - Write mtime_hi=0x0000_0001, mtime_lo=0xFFFF_FFFF, then arlen=1 burst at 0x0 -> beats
//   {lo,hi} coherent from one snapshot (hi=1 unless lo was captured already wrapped).
// - Write 0x0 with wstrb=4'b0010, wdata=0x0000_AB00 -> only byte1 of mtime_lo changes; bresp=OKAY.
// - Read 0x0200_0010 -> rdata=0, rresp=2'b10; write there -> bresp=2'b10, mtime unchanged.
// - rready held low 5 cycles mid-burst -> rvalid, rdata, rlast stable; arready stays 0 until last.
// - Assert reset during W_DATA -> all outputs at reset values, next AW accepted cleanly, mtime=0.

Source files
------------

// File: rtl/ysyx_24100029_clint_pkg.sv
// Shared constants, state encodings and helpers for the core-local timer (CLINT).
package ysyx_24100029_clint_pkg;

  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [15:0] MTIME_LO   = 16'h0000;
  localparam logic [15:0] MTIME_HI   = 16'h0004;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    SEL_LO,
    SEL_HI,
    SEL_NONE
  } word_sel_e;

  // Map a bus address onto one of the two mtime words, or nothing.
  function automatic word_sel_e decode_word(input logic [31:0] addr, input logic [15:0] mask);
    logic [31:0] off;
    off = addr & {16'h0000, mask};
    if (off == {16'h0000, MTIME_LO})      return SEL_LO;
    else if (off == {16'h0000, MTIME_HI}) return SEL_HI;
    else                                  return SEL_NONE;
  endfunction

  // FIXED bursts stay on one address; INCR and WRAP both step by a word.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

  // Replace only the byte lanes enabled in strb.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_24100029_clint_timer.sv
// Prescaler plus free-running 64-bit mtime with a byte-granular word write port.
module ysyx_24100029_clint_timer
  import ysyx_24100029_clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  output logic [63:0] mtime,
  output logic        tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [63:0]   mtime_inc;
  logic [63:0]   mtime_next;

  assign tick = (prescaler == PW'(TICK_DIV - 1));

  // Prescaler wraps after TICK_DIV cycles; the wrap is the mtime tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prescaler <= '0;
    else if (tick) prescaler <= '0;
    else prescaler <= prescaler + PW'(1);
  end

  // A written word takes the bus value and loses this cycle's tick; the other word keeps its increment/carry.
  always_comb begin
    mtime_inc  = mtime + 64'(tick);
    mtime_next = mtime_inc;
    if (wr_en) begin
      if (wr_hi) mtime_next[63:32] = merge_bytes(mtime[63:32], wr_data, wr_strb);
      else       mtime_next[31:0]  = merge_bytes(mtime[31:0],  wr_data, wr_strb);
    end
  end

  // mtime register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mtime <= '0;
    else mtime <= mtime_next;
  end

endmodule

// File: rtl/ysyx_24100029_clint.sv
// AXI4 slave front end of the CLINT: independent read and write channel FSMs around the timer.
module ysyx_24100029_clint
  import ysyx_24100029_clint_pkg::*;
#(
  parameter int          TICK_DIV  = 1,
  parameter logic [15:0] ADDR_MASK = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  logic [63:0] mtime;
  logic        tick;
  logic        unused_ok;

  rd_state_e   r_state, r_state_next;
  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [7:0]  r_len, r_beat;
  logic [1:0]  r_burst;
  logic [63:0] r_snap;
  word_sel_e   r_sel;
  logic        ar_fire, r_fire;

  wr_state_e   w_state, w_state_next;
  logic [31:0] w_addr;
  logic [3:0]  w_id;
  logic [1:0]  w_burst;
  logic        w_err;
  word_sel_e   w_sel;
  logic        aw_fire, w_fire, b_fire;

  // Sizes are ignored (full-word data) and beat count is set by wlast, not awlen.
  assign unused_ok = ^{awsize, arsize, awlen, tick};

  assign ar_fire = arvalid & arready;
  assign r_fire  = rvalid & rready;
  assign r_sel   = decode_word(r_addr, ADDR_MASK);
  assign rid     = r_id;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign b_fire  = bvalid & bready;
  assign w_sel   = decode_word(w_addr, ADDR_MASK);
  assign bid     = w_id;

  ysyx_24100029_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_fire && (w_sel != SEL_NONE)),
    .wr_hi   (w_sel == SEL_HI),
    .wr_data (wdata),
    .wr_strb (wstrb),
    .mtime   (mtime),
    .tick    (tick)
  );

  // Read channel state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else r_state <= r_state_next;
  end

  // Read channel next state: leave R_DATA only when the last beat is taken.
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_next = R_DATA;
      R_DATA:  if (r_fire && rlast) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read channel outputs: data comes from the snapshot so multi-beat reads are coherent.
  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rlast   = rvalid && (r_beat == r_len);
    rdata   = 32'h0;
    rresp   = RESP_OKAY;
    if (rvalid) begin
      case (r_sel)
        SEL_LO:  rdata = r_snap[31:0];
        SEL_HI:  rdata = r_snap[63:32];
        default: rresp = RESP_SLVERR;
      endcase
    end
  end

  // Read datapath: capture request and mtime snapshot on AR, step address per beat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_snap  <= '0;
    end else if (ar_fire) begin
      r_addr  <= araddr;
      r_id    <= arid;
      r_len   <= arlen;
      r_beat  <= '0;
      r_burst <= arburst;
      r_snap  <= mtime;
    end else if (r_fire && !rlast) begin
      r_addr <= next_beat_addr(r_addr, r_burst);
      r_beat <= r_beat + 8'd1;
    end
  end

  // Write channel state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else w_state <= w_state_next;
  end

  // Write channel next state: wlast alone ends the data phase.
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_next = W_DATA;
      W_DATA:  if (w_fire && wlast) w_state_next = W_RESP;
      W_RESP:  if (b_fire) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write channel outputs.
  always_comb begin
    awready = (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
  end

  // Write datapath: latch AW, step address per beat, accumulate sticky error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_addr  <= '0;
      w_id    <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= awaddr;
      w_id    <= awid;
      w_burst <= awburst;
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr <= next_beat_addr(w_addr, w_burst);
      if (w_sel == SEL_NONE) w_err <= 1'b1;
    end
  end

endmodule
